// File: rtl/multdiv_seq_if.sv
// Start/operand/result bundle between the control path and the multiply/divide unit.
// The control path is the master; multdiv_seq is the slave.
interface multdiv_seq_if;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_seq.sv
// Sequential signed multiply (shift-add) and divide (restoring), 32 iterations each.
// Define MULTDIV_OVF_EN for a 64-bit product accumulator with signed multiply overflow reporting.
module multdiv_seq (
  input logic          clock,
  input logic          reset,
  multdiv_seq_if.slave bus
);

`ifdef MULTDIV_OVF_EN
  localparam int ACC_W = 64;
`else
  localparam int ACC_W = 32;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  logic [4:0]       count;
  // op_a holds the multiplicand, or the dividend bits still to be shifted in (MSB first).
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic             sign;
  logic [ACC_W-1:0] acc;
  logic [31:0]      rem;
  logic [31:0]      quo;

  logic [31:0]      abs_a;
  logic [31:0]      abs_b;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] prod_signed;
  logic             ovf;
  logic [31:0]      rem_shift;
  logic             ge;
  logic [31:0]      rem_next;
  logic [31:0]      quo_next;
  logic [31:0]      quo_signed;

  always_comb begin
    abs_a       = bus.data_operandA[31] ? -bus.data_operandA : bus.data_operandA;
    abs_b       = bus.data_operandB[31] ? -bus.data_operandB : bus.data_operandB;

    addend      = op_b[count] ? (ACC_W'(op_a) << count) : '0;
    acc_next    = acc + addend;
    prod_signed = sign ? -acc_next : acc_next;
`ifdef MULTDIV_OVF_EN
    ovf         = prod_signed[63:32] != {32{prod_signed[31]}};
`else
    ovf         = 1'b0;
`endif

    // Remainder stays below the divisor (at most 2^31), so the shifted value fits in 32 bits.
    rem_shift   = {rem[30:0], op_a[31]};
    ge          = rem_shift >= op_b;
    rem_next    = ge ? rem_shift - op_b : rem_shift;
    quo_next    = {quo[30:0], ge};
    quo_signed  = sign ? -quo_next : quo_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      count              <= '0;
      op_a               <= '0;
      op_b               <= '0;
      sign               <= 1'b0;
      acc                <= '0;
      rem                <= '0;
      quo                <= '0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (bus.ctrl_MULT) begin
            op_a     <= abs_a;
            op_b     <= abs_b;
            sign     <= bus.data_operandA[31] ^ bus.data_operandB[31];
            acc      <= '0;
            bus.busy <= 1'b1;
            state    <= MUL;
          end else if (bus.ctrl_DIV) begin
            bus.busy <= 1'b1;
            if (bus.data_operandB == '0) begin
              bus.data_result    <= '0;
              bus.data_exception <= 1'b1;
              bus.data_resultRDY <= 1'b1;
              state              <= DONE;
            end else begin
              op_a  <= abs_a;
              op_b  <= abs_b;
              sign  <= bus.data_operandA[31] ^ bus.data_operandB[31];
              rem   <= '0;
              quo   <= '0;
              state <= DIV;
            end
          end
        end

        MUL: begin
          acc   <= acc_next;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            bus.data_result    <= prod_signed[31:0];
            bus.data_exception <= ovf;
            bus.data_resultRDY <= 1'b1;
            state              <= DONE;
          end
        end

        DIV: begin
          rem   <= rem_next;
          quo   <= quo_next;
          op_a  <= op_a << 1;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            bus.data_result    <= quo_signed;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b1;
            state              <= DONE;
          end
        end

        DONE: begin
          bus.data_resultRDY <= 1'b0;
          bus.busy           <= 1'b0;
          state              <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: a vector table run back-to-back through a result scoreboard,
// then hand-written sequences for ignored strobes, simultaneous strobes and reset abort.
`timescale 1ns/1ps
module tb_multdiv_seq;

`ifdef MULTDIV_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          lat;
  } exp_t;

  typedef struct {
    bit          mul;
    bit          div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          exc;
    bit          ovf;
    int          lat;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int unsigned issue_cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  vec_t        vecs[17];

  multdiv_seq_if bus();

  multdiv_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge; the strobe is sampled on the next rising edge.
  task automatic applyStimulus(input bit mul, input bit div, input logic [31:0] a,
                               input logic [31:0] b, input exp_t e);
    sb.push_back(e);
    bus.ctrl_MULT     = mul;
    bus.ctrl_DIV      = div;
    bus.data_operandA = a;
    bus.data_operandB = b;
    issue_cyc         = cyc;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
  endtask

  // With inject set, a divide-by-zero strobe is pulsed mid-operation and again during DONE.
  task automatic checkOutput(input string tag, input bit inject);
    int   busy_cnt;
    int   off;
    bit   seen;
    exp_t e;
    busy_cnt = 0;
    off      = 0;
    seen     = 1'b0;
    for (int n = 0; n < 100; n++) begin
      off = int'(cyc - issue_cyc);
      if (inject) begin
        bus.ctrl_DIV      = (off == 10) || (off == 33);
        bus.data_operandA = 32'd5;
        bus.data_operandB = 32'd0;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.data_resultRDY === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    e = sb.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got no data_resultRDY expected one within 100 cycles", tag);
    end else begin
      check({tag, "_result"}, bus.data_result, e.res);
      check({tag, "_exception"}, {31'd0, bus.data_exception}, {31'd0, e.exc});
      check({tag, "_latency"}, off, e.lat);
      check({tag, "_busy_cycles"}, busy_cnt, e.lat);
    end
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    check({tag, "_rdy_after"}, {31'd0, bus.data_resultRDY}, 32'd0);
    check({tag, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int   rdy_cnt;

    vecs[0]  = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0, 33};
    vecs[1]  = '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 1'b1, 33};
    vecs[2]  = '{1'b1, 1'b0, 32'd0,        32'd5,        32'd0,        1'b0, 1'b0, 33};
    vecs[3]  = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'd20,       1'b0, 1'b0, 33};
    vecs[4]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b0, 1'b1, 33};
    vecs[5]  = '{1'b1, 1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0, 1'b0, 33};
    vecs[6]  = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 33};
    vecs[7]  = '{1'b1, 1'b0, 32'h00003039, 32'h00000010, 32'h00030390, 1'b0, 1'b0, 33};
    vecs[8]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 33};
    vecs[9]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0, 1'b0, 33};
    vecs[10] = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 33};
    vecs[11] = '{1'b0, 1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 1'b0, 33};
    vecs[12] = '{1'b0, 1'b1, 32'd7,        32'd100,      32'd0,        1'b0, 1'b0, 33};
    vecs[13] = '{1'b0, 1'b1, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b0, 33};
    vecs[14] = '{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'd1,        1'b0, 1'b0, 33};
    vecs[15] = '{1'b0, 1'b1, 32'd5,        32'd0,        32'd0,        1'b1, 1'b0, 1};
    vecs[16] = '{1'b0, 1'b1, 32'hFFFFFFF7, 32'hFFFFFFFE, 32'd4,        1'b0, 1'b0, 33};

    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_result", bus.data_result, 32'd0);
    check("reset_exception", {31'd0, bus.data_exception}, 32'd0);
    check("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);

    // Each operation starts in the first IDLE cycle after the previous one.
    for (int i = 0; i < 17; i++) begin
      e.res = vecs[i].res;
      e.exc = vecs[i].exc | (OVF_EN & vecs[i].ovf);
      e.lat = vecs[i].lat;
      applyStimulus(vecs[i].mul, vecs[i].div, vecs[i].a, vecs[i].b, e);
      checkOutput($sformatf("vec%0d", i), 1'b0);
    end

    e = '{32'h0000369C, 1'b0, 33};
    applyStimulus(1'b1, 1'b0, 32'h00001234, 32'd3, e);
    checkOutput("ignored_div", 1'b1);

    e = '{32'd15, 1'b0, 33};
    applyStimulus(1'b1, 1'b1, 32'd3, 32'd5, e);
    checkOutput("both_strobes", 1'b0);

    // Abort a divide with reset during its 15th cycle; no completion may follow.
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 32'hFFFFFF9C;
    bus.data_operandB = 32'd7;
    issue_cyc         = cyc;
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    rdy_cnt      = 0;
    while (int'(cyc - issue_cyc) < 15) begin
      if (bus.data_resultRDY === 1'b1) rdy_cnt++;
      @(negedge clock);
    end
    check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_result", bus.data_result, 32'd0);
    check("abort_exception", {31'd0, bus.data_exception}, 32'd0);
    check("abort_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_no_rdy", rdy_cnt, 32'd0);
    @(negedge clock);
    e = '{32'd42, 1'b0, 33};
    applyStimulus(1'b1, 1'b0, 32'd6, 32'd7, e);
    checkOutput("after_abort", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion expected end of test before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Multicycle integer multiply/divide unit for the processor datapath. It accepts one-cycle start strobes from the control path for the R-type `mul` (Func 00110) and `div` (Func 00111) operations. It sequences a shift-add multiplier or a restoring divider over 32 iterations and returns a registered 32-bit result with a ready strobe. While busy it drives a stall so the pipeline holds the issuing instruction.

## Interface
- No parameters; data width fixed at 32 bits.
- `clock`  input  1  rising-edge clock for all state.
- `reset`  input  1  synchronous, active-high reset.
- `ctrl_MULT`  input  1  one-cycle start strobe for signed multiply.
- `ctrl_DIV`  input  1  one-cycle start strobe for signed divide.
- `data_operandA`  input  32  multiplicand or dividend, signed two's complement, sampled only on an accepted start.
- `data_operandB`  input  32  multiplier or divisor, signed two's complement, sampled only on an accepted start.
- `data_result`  output  32  product low word or quotient; registered and held until the next completion.
- `data_exception`  output  1  divide-by-zero, or multiply overflow (see Configuration); valid with `data_result`.
- `data_resultRDY`  output  1  one-cycle completion strobe.
- `busy`  output  1  high from the cycle after an accepted start through the DONE cycle; the pipeline stall source.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset state: IDLE.
- Reset values: `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0; internal counter and operand registers are cleared.
- **IDLE:** a start is accepted only in IDLE.
  - `ctrl_MULT`=1: latch |A|, |B| and sign = A[31]^B[31]; clear the accumulator and counter; go to MUL.
  - `ctrl_DIV`=1 with B≠0: latch |A|, |B| and quotient sign; clear the remainder and counter; go to DIV.
  - `ctrl_DIV`=1 with B=0: go straight to DONE; the result is 0 and the exception is 1.
  - If both strobes are high in the same cycle, the operation is MULT.
  - Start strobes in any state other than IDLE are ignored; there is no queueing.
- **MUL:** one iteration per cycle, counter 0..31.
  - If multiplier bit[count] is 1, add the multiplicand shifted left by count into the accumulator.
  - After count 31, negate the accumulator if the sign is set, load the low 32 bits into `data_result`, and go to DONE.
- **DIV:** restoring division, one quotient bit per cycle from MSB to LSB, counter 0..31.
  - Shift the remainder left by 1 and append the next dividend bit.
  - If remainder ≥ |B|: subtract |B| and set the quotient bit to 1; otherwise set it to 0.
  - After count 31, negate the quotient if the sign is set, load it into `data_result`, and go to DONE.
  - The remainder is discarded.
  - Quotients truncate toward zero.
  - Overflow case: 0x80000000 / 0xFFFFFFFF wraps to 0x80000000 with the exception at 0.
- **DONE:** assert `data_resultRDY` for exactly one cycle, then go to IDLE. `data_result` and `data_exception` hold until the next DONE.
- Magnitude arithmetic is 32-bit unsigned, so |0x80000000| = 0x80000000.
- A `reset` in any state aborts the operation. No `data_resultRDY` is produced, and all outputs return to their reset values on the next edge.

## Timing
- Start sampled at edge E0 (cycle T). `busy` is 1 in cycles T+1..T+33.
- MUL or DIV occupies T+1..T+32; DONE with `data_resultRDY`=1 is T+33. Latency is 33 cycles.
- Divide-by-zero: DONE and `data_resultRDY` in T+1, `busy`=1 in T+1 only. Latency is 1 cycle.
- Earliest back-to-back start is cycle T+34, the first IDLE cycle. A strobe arriving during DONE is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `MULTDIV_OVF_EN` defined:
  - The accumulator is 64 bits.
  - For MULT, `data_exception`=1 when the signed 64-bit product's high word is not the sign extension of bit 31.
  - `data_result` is still the low word.
- `MULTDIV_OVF_EN` undefined:
  - The accumulator is 32 bits.
  - `data_exception` is always 0 for MULT.
  - Divide-by-zero reporting is unchanged.

## Test plan
- MULT A=7, B=-3 → at T+33 `data_resultRDY`=1, `data_result`=0xFFFFFFEB, `data_exception`=0; `busy`=1 for exactly 33 cycles.
- DIV A=-100, B=7 → at T+33 `data_result`=0xFFFFFFF2 (-14), `data_exception`=0; DIV 0x80000000/0xFFFFFFFF → 0x80000000, exception 0.
- DIV A=5, B=0 → at T+1 `data_resultRDY`=1, `data_result`=0, `data_exception`=1; IDLE at T+2.
- MULT A=0x00010000, B=0x00010000 → `data_result`=0; `data_exception`=1 with `MULTDIV_OVF_EN`, 0 without.
- `ctrl_DIV` pulsed at T+10 of a MULT, and both strobes high together in IDLE → the second strobe is ignored and the MULT result is unaffected; the simultaneous case performs MULT.
- `reset` at T+15 of a DIV → all outputs 0 at T+16, no `data_resultRDY`; a new MULT 6×7 issued at T+17 gives 42 at T+50.
